// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: a - b - bin over WIDTH bits, one 4-bit borrow-lookahead
// slice per clock (LSB nibble first), with a start/busy/done handshake.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             borrow_reg, borrow_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic             bout_reg, bout_next;
    logic             zero_reg, zero_next;
    logic             ovf_reg, ovf_next;
    logic             done_reg, done_next;

    // Borrow-lookahead slice on the current (lowest) nibble of the shift registers
    logic [3:0] x, y, g, p, d;
    logic [4:0] c;

    assign x    = a_reg[3:0];
    assign y    = b_reg[3:0];
    assign c[0] = borrow_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            assign g[gi] = ~x[gi] & y[gi];
            assign p[gi] = ~(x[gi] ^ y[gi]);
            assign d[gi] = x[gi] ^ y[gi] ^ c[gi];
        end
    endgenerate

    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

    // acc_shift is the partial difference with the current nibble placed on top;
    // after the last nibble it is the complete result.
    logic [WIDTH-1:0] a_shift, b_shift, acc_shift;

    generate
        if (NIB == 1) begin : g_single
            assign a_shift   = a_reg;
            assign b_shift   = b_reg;
            assign acc_shift = d;
        end else begin : g_multi
            logic [WIDTH-5:0] part_reg;

            assign a_shift   = {4'b0000, a_reg[WIDTH-1:4]};
            assign b_shift   = {4'b0000, b_reg[WIDTH-1:4]};
            assign acc_shift = {d, part_reg};

            always_ff @(posedge clk) begin
                if (rst) begin
                    part_reg <= '0;
                end else if (state_reg == RUN) begin
                    part_reg <= acc_shift[WIDTH-1:4];
                end
            end
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        borrow_next = borrow_reg;
        diff_next   = diff_reg;
        bout_next   = bout_reg;
        zero_next   = zero_reg;
        ovf_next    = ovf_reg;
        done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = RUN;
                    cnt_next    = '0;
                    a_next      = a;
                    b_next      = b;
                    borrow_next = bin;
                end
            end
            RUN: begin
                a_next      = a_shift;
                b_next      = b_shift;
                borrow_next = c[4];
                cnt_next    = cnt_reg + CW'(1);
                if (cnt_reg == LAST) begin
                    // On the last nibble x[3]/y[3] are the operand sign bits
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                    diff_next  = acc_shift;
                    bout_next  = c[4];
                    zero_next  = (acc_shift == '0);
                    ovf_next   = (x[3] != y[3]) && (d[3] != x[3]);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            borrow_reg <= 1'b0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            borrow_reg <= borrow_next;
            diff_reg   <= diff_next;
            bout_reg   <= bout_next;
            zero_reg   <= zero_next;
            ovf_reg    <= ovf_next;
            done_reg   <= done_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = done_reg;
    assign diff = diff_reg;
    assign bout = bout_reg;
    assign zero = zero_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor: a WIDTH=16 instance with directed,
// handshake, reset and random tests, plus an exhaustive WIDTH=4 instance.
module tb_nibble_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, bin;
    logic [15:0] a, b;
    logic        busy, done, bout, zero, ovf;
    logic [15:0] diff;

    logic        start4, bin4;
    logic [3:0]  a4, b4;
    logic        busy4, done4, bout4, zero4, ovf4;
    logic [3:0]  diff4;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] diff;
        logic        bout;
        logic        zero;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [3:0] diff;
        logic       bout;
        logic       zero;
        logic       ovf;
    } exp4_t;

    exp_t  sb[$];
    exp4_t sb4[$];

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
    );

    nibble_serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4), .ovf(ovf4)
    );

    function automatic exp_t model16(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        logic [16:0] r;
        exp_t m;
        r      = {1'b0, av} - {1'b0, bv} - {16'd0, cv};
        m.diff = r[15:0];
        m.bout = r[16];
        m.zero = (r[15:0] == 16'd0);
        m.ovf  = (av[15] != bv[15]) && (r[15] != av[15]);
        return m;
    endfunction

    function automatic exp4_t model4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
        logic [4:0] r;
        exp4_t m;
        r      = {1'b0, av} - {1'b0, bv} - {4'd0, cv};
        m.diff = r[3:0];
        m.bout = r[4];
        m.zero = (r[3:0] == 4'd0);
        m.ovf  = (av[3] != bv[3]) && (r[3] != av[3]);
        return m;
    endfunction

    // Called at a falling edge; drives start with operands and optionally books the result.
    task automatic drive(input logic [15:0] av, input logic [15:0] bv, input logic cv, input bit push);
        a     = av;
        b     = bv;
        bin   = cv;
        start = 1'b1;
        if (push) sb.push_back(model16(av, bv, cv));
    endtask

    // Waits for done (bounded), checks latency/busy/overlap, pops and compares the result.
    task automatic wait_done(input string name, input int exp_lat, input bit clr);
        bit   seen = 0;
        bit   overlap = 0;
        bit   busy_bad = 0;
        int   lat = 0;
        exp_t e;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 1 && clr) start = 1'b0;
            if (busy && done) overlap = 1;
            if (done) begin
                seen = 1;
                lat  = i;
            end else if (!busy) begin
                busy_bad = 1;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: done=%0b required=1 within 20 cycles", name, done);
            return;
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        checks++;
        if (overlap || busy_bad) begin
            errors++;
            $display("FAIL %s handshake: overlap=%0b busy_dropped=%0b required 0/0", name, overlap, busy_bad);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: unexpected done, queue empty", name);
            return;
        end
        e = sb.pop_front();
        if (diff !== e.diff || bout !== e.bout || zero !== e.zero || ovf !== e.ovf) begin
            errors++;
            $display("FAIL %s result: diff=%h bout=%b zero=%b ovf=%b required diff=%h bout=%b zero=%b ovf=%b",
                     name, diff, bout, zero, ovf, e.diff, e.bout, e.zero, e.ovf);
        end else begin
            $display("txn %s diff=%h bout=%b zero=%b ovf=%b lat=%0d", name, diff, bout, zero, ovf, lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, diff, bout, zero, ovf} !== 20'd0) begin
            errors++;
            $display("FAIL reset16: busy=%b done=%b diff=%h bout=%b zero=%b ovf=%b required all 0",
                     busy, done, diff, bout, zero, ovf);
        end
        checks++;
        if ({busy4, done4, diff4, bout4, zero4, ovf4} !== 8'd0) begin
            errors++;
            $display("FAIL reset4: busy=%b done=%b diff=%h required all 0", busy4, done4, diff4);
        end
        rst = 1'b0;
        $display("txn reset");
    endtask

    task automatic test_basic();
        logic [15:0] ta [5] = '{16'h0000, 16'h8000, 16'h5555, 16'hABCD, 16'h0000};
        logic [15:0] tb_ [5] = '{16'h0001, 16'h0001, 16'h5554, 16'hABCD, 16'h0000};
        logic        tc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        drive(16'h1234, 16'h0234, 1'b0, 1);
        wait_done("basic", 5, 1);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || diff !== 16'h1000) begin
            errors++;
            $display("FAIL pulse_hold: done=%b diff=%h required done=0 diff=1000", done, diff);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(ta[i], tb_[i], tc[i], 1);
            wait_done("directed", 5, 1);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(16'h0010, 16'h0001, 1'b0, 1);
        @(negedge clk);
        drive(16'hFFFF, 16'hFFFF, 1'b0, 0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy: busy=%b required 1", busy);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_busy", 3, 0);
        drive(16'h0003, 16'h0001, 1'b0, 1);
        wait_done("back_to_back", 5, 1);
    endtask

    task automatic test_held_start();
        @(negedge clk);
        drive(16'h0100, 16'h0001, 1'b1, 1);
        sb.push_back(model16(16'h0100, 16'h0001, 1'b1));
        wait_done("held1", 5, 0);
        wait_done("held2", 5, 1);
    endtask

    task automatic test_reset_abort();
        bit saw_done = 0;
        @(negedge clk);
        drive(16'h1234, 16'h0001, 1'b0, 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, diff, bout, zero, ovf} !== 20'd0) begin
            errors++;
            $display("FAIL abort_clear: busy=%b done=%b diff=%h bout=%b zero=%b ovf=%b required all 0",
                     busy, done, diff, bout, zero, ovf);
        end
        repeat (6) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: done pulsed=1 required 0");
        end
        drive(16'h0009, 16'h0004, 1'b0, 1);
        wait_done("after_abort", 5, 1);
    endtask

    task automatic test_random();
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom), 1);
            wait_done("random", 5, 1);
        end
    endtask

    task automatic test_width4();
        exp4_t e;
        logic [8:0] v;
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            @(negedge clk);
            a4 = v[3:0]; b4 = v[7:4]; bin4 = v[8]; start4 = 1'b1;
            sb4.push_back(model4(v[3:0], v[7:4], v[8]));
            @(negedge clk);
            start4 = 1'b0;
            @(negedge clk);
            e = sb4.pop_front();
            checks++;
            if (done4 !== 1'b1 || busy4 !== 1'b0 || diff4 !== e.diff || bout4 !== e.bout
                || zero4 !== e.zero || ovf4 !== e.ovf) begin
                errors++;
                $display("FAIL w4 a=%h b=%h bin=%b: done=%b busy=%b diff=%h bout=%b zero=%b ovf=%b required done=1 busy=0 diff=%h bout=%b zero=%b ovf=%b",
                         v[3:0], v[7:4], v[8], done4, busy4, diff4, bout4, zero4, ovf4,
                         e.diff, e.bout, e.zero, e.ovf);
            end else begin
                $display("txn w4 a=%h b=%h bin=%b diff=%h bout=%b", v[3:0], v[7:4], v[8], diff4, bout4);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_held_start();
        test_reset_abort();
        test_random();
        test_width4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
Multi-cycle unsigned/two's-complement subtractor computing a - b - bin over WIDTH bits. It processes one 4-bit slice per clock, LSB nibble first, using a 4-bit borrow-lookahead slice, and chains the borrow between slices through a register. This is the inverse-direction companion to the team's 4-bit CLA adder slice, for datapaths that need area-cheap wide subtract and compare. It uses a start/busy/done handshake and holds its result until the next operation completes.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4 (NIB = WIDTH/4 slices).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when idle (busy=0)
a  input  WIDTH  minuend; sampled with start
b  input  WIDTH  subtrahend; sampled with start
bin  input  1  borrow-in; sampled with start
busy  output  1  high while slices are being processed
done  output  1  one-cycle pulse; results valid from this cycle on
diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
bout  output  1  final borrow; 1 iff a < b + bin (unsigned)
zero  output  1  diff == 0
ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB]

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy, done, diff, bout, zero, ovf all 0; internal operand/borrow registers cleared. Reset has priority over everything, including an in-flight operation. The aborted result is discarded and done is not pulsed.
- States: IDLE, RUN.
  - IDLE -> RUN: on an edge with start=1. At that edge, latch a, b into shift registers, latch bin into the borrow register, set nibble counter=0, busy=1.
  - RUN: at each edge, compute the current nibble (counter value) and increment the counter. When counter==NIB-1: state -> IDLE, busy=0, done=1 for exactly one cycle.
- Slice math per nibble, with x = a-nibble, y = b-nibble, c0 = registered borrow:
  - g = ~x & y, p = ~(x ^ y).
  - c(i+1) = g(i) | (p(i) & c(i)), using lookahead within the nibble.
  - d(i) = x(i) ^ y(i) ^ c(i).
  - c4 goes to the borrow register for the next nibble.
- Latency: start sampled at edge E0 -> done high during the cycle after edge E0+NIB. For WIDTH=16 this is 4 clocks; throughput is one operation per NIB clocks.
- Output update: diff, bout, zero and ovf change only at the completion edge (the same edge that raises done). They hold their values until the next completion or reset; partial results are never visible.
- Handshake:
  - start while busy=1 is ignored; the operands are not resampled.
  - start high in the done cycle (state IDLE) is accepted, giving back-to-back operation with no gap cycle.
  - done is never high at the same time as busy.
  - A held-high start re-triggers each time the block returns to IDLE.
- Boundaries:
  - bin=1 with a==b gives diff all-ones and bout=1.
  - a=0, b=0, bin=0 gives zero=1 and bout=0.
  - Wrap-around is modulo 2^WIDTH; the borrow is reported only on bout.
  - The counter wraps to 0 on entry to IDLE.
  - WIDTH=4 degenerates to a single RUN cycle, with done high one clock after start.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0234, bin=0 -> exactly 4 clocks after the start edge: diff=0x1000, bout=0, zero=0, ovf=0, done pulses for 1 cycle; busy high for the 4 intervening cycles.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, zero=0, ovf=0. Then a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1.
- a=0x5555, b=0x5554, bin=1 -> diff=0x0000, zero=1, bout=0. Then a=b=0xABCD, bin=1 -> diff=0xFFFF, bout=1.
- Pulse start with a=0x0010, b=0x0001; in the next RUN cycle assert start with a=0xFFFF, b=0xFFFF -> result diff=0x000F (second start ignored). Assert start again in the done cycle with a=0x0003, b=0x0001 -> diff=0x0002 done 4 clocks later, no idle gap.
- Start an operation, assert rst for 1 cycle in the 2nd RUN cycle -> all outputs 0, busy=0, no done pulse. A following start with a=0x0009, b=0x0004 completes normally with diff=0x0005.
- Self-check: 1000 random {a,b,bin} vectors, plus a WIDTH=4 instance exhaustive over all 512 combinations, compared against {bout,diff} = {1'b0,a} - {1'b0,b} - bin plus zero/ovf formulas -> error count 0; print "success" or the error count.
